// File: rtl/fetch_stage.sv
// fetch_stage: two-state instruction fetch with wait timeout/reissue and PC redirect.
// Optional delivered-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        IMemValid,
  output logic [31:0] Instruction,
  output logic        InstValid,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  output logic [31:0] PC,
  output logic [31:0] FetchCount
);
  typedef enum logic {FETCH, DELIVER} state_t;
  localparam int WW = $clog2(IMEM_TIMEOUT + 1);
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, instr_q, instr_d, pc4, next_pc;
  logic          valid_q, valid_d, req_q, req_d, consume;
  logic [WW-1:0] wait_q, wait_d;
  assign pc4     = pc_q + 32'd4;
  assign next_pc = Jump ? {pc4[31:28], JumpTarget, 2'b00} : BranchTaken ? pc4 + (BranchOffset << 2) : pc4;
  assign consume = state_q == DELIVER && !Stall;
  // req_q low in FETCH marks the post-reset or post-timeout gap; IMemValid is ignored then
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    wait_d  = wait_q;
    if (state_q == FETCH) begin
      if (!req_q) req_d = 1'b1;
      else if (IMemValid) begin
        state_d = DELIVER;
        instr_d = IMemRdata;
        valid_d = 1'b1;
        req_d   = 1'b0;
        wait_d  = '0;
      end else if (wait_q == WW'(IMEM_TIMEOUT - 1)) begin
        wait_d = '0;
        req_d  = 1'b0;
      end else wait_d = wait_q + WW'(1);
    end else if (consume) begin
      state_d = FETCH;
      pc_d    = next_pc;
      instr_d = '0;
      valid_d = 1'b0;
      req_d   = 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = consume ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign FetchCount = cnt_q;
`else
  assign FetchCount = 32'h0;
`endif
  assign IMemReq     = req_q;
  assign IMemAddr    = pc_q;
  assign Instruction = instr_q;
  assign InstValid   = valid_q;
  assign PC          = pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          TO       = 16;
`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic        Clk = 1'b0, Reset = 1'b1;
  logic        IMemReq, InstValid;
  logic [31:0] IMemAddr, Instruction, PC, FetchCount;
  logic [31:0] IMemRdata = '0, BranchOffset = '0;
  logic        IMemValid = 1'b0, Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0;
  logic [25:0] JumpTarget = '0;
  int          compared = 0, mismatched = 0;
  int          age = 0, lat = 0;
  bit          k_rand = 0, k_stall = 0, k_br = 0, k_jmp = 0, k_junk = 0, k_force = 0;
  logic [31:0] k_off = '0;
  logic [25:0] k_jt = '0;
  int          m_t;
  bit          m_present;
  logic [31:0] m_pc, m_instr, m_cnt;

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata),
    .IMemValid(IMemValid), .Instruction(Instruction), .InstValid(InstValid), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
    .PC(PC), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h2008_0005 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] npc(input logic [31:0] pc, input logic j, input logic [25:0] jt,
                                      input logic b, input logic [31:0] off);
    logic [31:0] p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) + {6'd0, jt} * 32'd4;
    if (b) return p4 + off * 32'd4;
    return p4;
  endfunction

  // m_t counts cycles since the fetch began; every (TO+1)th slot is the one-cycle request gap
  function automatic bit exp_req();
    return !m_present && m_t >= 0 && (m_t % (TO + 1)) != TO;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_t <= -1;
      m_present <= 1'b0;
      m_pc <= RESET_PC;
      m_instr <= '0;
      m_cnt <= '0;
    end else if (!m_present) begin
      if (exp_req() && IMemValid) begin
        m_present <= 1'b1;
        m_instr <= IMemRdata;
      end else m_t <= m_t + 1;
    end else if (!Stall) begin
      m_present <= 1'b0;
      m_pc <= npc(m_pc, Jump, JumpTarget, BranchTaken, BranchOffset);
      m_instr <= '0;
      m_t <= 0;
      m_cnt <= m_cnt + 32'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [15:0] r;
    @(posedge Clk);
    #1;
    chk("IMemReq", {31'd0, IMemReq}, {31'd0, exp_req()});
    if (exp_req()) chk("IMemAddr", IMemAddr, m_pc);
    chk("InstValid", {31'd0, InstValid}, {31'd0, m_present});
    chk("Instruction", Instruction, m_instr);
    chk("PC", PC, m_pc);
    chk("FetchCount", FetchCount, CNT_EN ? m_cnt : 32'h0);
    if (k_rand) begin
      r = 16'($urandom);
      k_stall = ($urandom % 3) == 0;
      k_br = ($urandom % 3) == 0;
      k_jmp = ($urandom % 5) == 0;
      k_off = {{16{r[15]}}, r};
      k_jt = 26'($urandom);
      k_junk = 1'b1;
      lat = $urandom_range(0, 4);
      if (lat == 4) lat = 30;
    end
    IMemValid = k_force ? 1'b1 : IMemReq ? (age >= lat) : (k_junk ? 1'($urandom) : 1'b0);
    IMemRdata = IMemReq ? mem(IMemAddr) : $urandom;
    age = IMemReq ? age + 1 : 0;
    Stall = k_stall;
    BranchTaken = k_br;
    BranchOffset = k_off;
    Jump = k_jmp;
    JumpTarget = k_jt;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!InstValid && n < 100) begin
      step();
      n++;
    end
    chk("wait_valid", {31'd0, InstValid}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, p, ins;
    int n;
    #2 Reset = 1'b0;
    repeat (3) step();
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'd0, InstValid}, 32'd0);
    chk("rst_cnt", FetchCount, 32'h0);
    Reset = 1'b1;
    step();
    chk("first_req", {31'd0, IMemReq}, 32'd1);
    chk("first_addr", IMemAddr, 32'h0);
    step();
    chk("first_valid", {31'd0, InstValid}, 32'd1);
    chk("first_instr", Instruction, 32'h2008_0005);
    chk("first_pc", PC, 32'h0);
    step();
    chk("pc_seq4", PC, 32'h4);
    chk("noop_after", Instruction, 32'h0);
    step();
    step();
    chk("pc_seq8", PC, 32'h8);
    wait_valid();
    Jump = 1'b1;
    JumpTarget = 26'h10;
    step();
    chk("jump_pc", PC, 32'h40);
    wait_valid();
    BranchTaken = 1'b1;
    BranchOffset = 32'hFFFF_FFFE;
    step();
    chk("branch_pc", PC, 32'h3C);
    wait_valid();
    step();
    chk("seq_pc", PC, 32'h40);
    wait_valid();
    BranchTaken = 1'b1;
    BranchOffset = 32'hFFFF_FFFE;
    Jump = 1'b1;
    JumpTarget = 26'h10;
    lat = 3;
    step();
    chk("jump_wins", PC, 32'h40);
    n = 0;
    a = IMemAddr;
    while (!InstValid && n < 20) begin
      if (IMemReq) begin
        n++;
        chk("wait_addr", IMemAddr, a);
      end
      step();
    end
    chk("req_cycles", n, 32'd4);
    Stall = 1'b1;
    k_stall = 1'b1;
    k_junk = 1'b1;
    p = PC;
    ins = Instruction;
    chk("stall_instr", ins, 32'hA5E5_0040);
    repeat (4) begin
      step();
      chk("stall_pc", PC, p);
      chk("stall_ins", Instruction, ins);
      chk("stall_vld", {31'd0, InstValid}, 32'd1);
      chk("stall_req", {31'd0, IMemReq}, 32'd0);
    end
    k_stall = 1'b0;
    k_junk = 1'b0;
    Stall = 1'b0;
    lat = 1000;
    step();
    a = IMemAddr;
    n = 0;
    while (IMemReq && n < 40) begin
      chk("to_addr", IMemAddr, a);
      n++;
      step();
    end
    chk("to_cycles", n, 32'd16);
    step();
    chk("reissue_req", {31'd0, IMemReq}, 32'd1);
    chk("reissue_addr", IMemAddr, 32'h44);
    step();
    step();
    Reset = 1'b0;
    k_force = 1'b1;
    IMemValid = 1'b1;
    IMemRdata = 32'hDEAD_BEEF;
    #1;
    chk("arst_req", {31'd0, IMemReq}, 32'd0);
    chk("arst_vld", {31'd0, InstValid}, 32'd0);
    chk("arst_pc", PC, RESET_PC);
    chk("arst_cnt", FetchCount, 32'h0);
    step();
    step();
    Reset = 1'b1;
    k_force = 1'b0;
    lat = 0;
    step();
    chk("post_rst_vld", {31'd0, InstValid}, 32'd0);
    chk("post_rst_req", {31'd0, IMemReq}, 32'd1);
    chk("post_rst_addr", IMemAddr, RESET_PC);
    wait_valid();
    BranchTaken = 1'b1;
    BranchOffset = 32'hFFFF_FFFE;
    step();
    chk("pc_top", PC, 32'hFFFF_FFFC);
    wait_valid();
    step();
    chk("pc_wrap", PC, 32'h0);
    repeat (8) begin
      wait_valid();
      step();
    end
    chk("count10", FetchCount, CNT_EN ? 32'd10 : 32'd0);
    k_rand = 1'b1;
    repeat (1500) step();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    repeat (1500) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
